// File: rtl/cross_product_seq.sv
// cross_product_seq: sequential 3-D signed cross product R = A x B.
// One shared W x W signed multiplier is time-multiplexed over six CALC cycles.
// Operands come in over a valid/ready handshake and results go out over another.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready  operand handshake; in_ready high only in IDLE
//   ax..az, bx..bz      W-bit signed components of A and B
//   out_valid, out_ready result handshake; result held while out_ready is low
//   rx, ry, rz          2W-bit signed components of R
//   busy                high while computing or holding a result
module cross_product_seq #(
  parameter int unsigned W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   ax,
  input  logic signed [W-1:0]   ay,
  input  logic signed [W-1:0]   az,
  input  logic signed [W-1:0]   bx,
  input  logic signed [W-1:0]   by,
  input  logic signed [W-1:0]   bz,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*W-1:0] rx,
  output logic signed [2*W-1:0] ry,
  output logic signed [2*W-1:0] rz,
  output logic                  busy
);

  localparam int unsigned RW = 2 * W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [2:0]            r_step;
  logic signed [W-1:0]   r_ax, r_ay, r_az, r_bx, r_by, r_bz;
  logic signed [RW-1:0]  r_acc_x, r_acc_y, r_acc_z;

  logic signed [W-1:0]   w_mul_a, w_mul_b;
  logic signed [RW-1:0]  w_prod;

  // Operand select for the shared multiplier, one product term per step
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_step)
      3'd0: begin w_mul_a = r_ay; w_mul_b = r_bz; end
      3'd1: begin w_mul_a = r_az; w_mul_b = r_by; end
      3'd2: begin w_mul_a = r_az; w_mul_b = r_bx; end
      3'd3: begin w_mul_a = r_ax; w_mul_b = r_bz; end
      3'd4: begin w_mul_a = r_ax; w_mul_b = r_by; end
      3'd5: begin w_mul_a = r_ay; w_mul_b = r_bx; end
      default: begin w_mul_a = '0; w_mul_b = '0; end
    endcase
  end

  // Operands are sign-extended to 2W first; the full product fits 2W bits
  assign w_prod = RW'(w_mul_a) * RW'(w_mul_b);

  // Control FSM, operand latches, accumulators and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_step    <= 3'd0;
      r_ax      <= '0;
      r_ay      <= '0;
      r_az      <= '0;
      r_bx      <= '0;
      r_by      <= '0;
      r_bz      <= '0;
      r_acc_x   <= '0;
      r_acc_y   <= '0;
      r_acc_z   <= '0;
      rx        <= '0;
      ry        <= '0;
      rz        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_ax     <= ax;
            r_ay     <= ay;
            r_az     <= az;
            r_bx     <= bx;
            r_by     <= by;
            r_bz     <= bz;
            r_step   <= 3'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_CALC;
          end
        end

        S_CALC: begin
          r_step <= r_step + 3'd1;
          case (r_step)
            3'd0: r_acc_x <= w_prod;
            3'd1: r_acc_x <= r_acc_x - w_prod;
            3'd2: r_acc_y <= w_prod;
            3'd3: r_acc_y <= r_acc_y - w_prod;
            3'd4: r_acc_z <= w_prod;
            3'd5: begin
              // Final subtraction goes straight into rz; results publish together
              rx        <= r_acc_x;
              ry        <= r_acc_y;
              rz        <= r_acc_z - w_prod;
              out_valid <= 1'b1;
              r_step    <= 3'd0;
              r_state   <= S_DONE;
            end
            default: r_step <= 3'd0;
          endcase
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_step    <= 3'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cross_product_seq.sv
// tb_cross_product_seq: scoreboard bench for cross_product_seq (W = 8).
// Accepted operand vectors push a reference result; a monitor pops on each
// output handshake and also checks the 6-edge latency.
module tb_cross_product_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned RW = 2 * W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   ax, ay, az, bx, by, bz;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [RW-1:0]  rx, ry, rz;
  logic                  busy;

  cross_product_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ax        (ax),
    .ay        (ay),
    .az        (az),
    .bx        (bx),
    .by        (by),
    .bz        (bz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rx        (rx),
    .ry        (ry),
    .rz        (rz),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint x;
    longint y;
    longint z;
    int     edge_no;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   rise_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_ov = 1'b0;
  exp_t e_mon;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Cross product straight from the vector definition
  function automatic exp_t model(input longint a_x, input longint a_y, input longint a_z,
                                 input longint b_x, input longint b_y, input longint b_z);
    exp_t r;
    r.x = a_y * b_z - a_z * b_y;
    r.y = a_z * b_x - a_x * b_z;
    r.z = a_x * b_y - a_y * b_x;
    r.edge_no = 0;
    return r;
  endfunction

  function automatic logic signed [W-1:0] rnd_comp();
    case ($urandom_range(0, 3))
      0:       return -(W'(1) <<< (W - 1));
      1:       return (W'(1) <<< (W - 1)) - W'(1);
      default: return W'($urandom());
    endcase
  endfunction

  // Acceptance monitor: the handshake completes on the following rising edge
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_t e;
      e = model(longint'(ax), longint'(ay), longint'(az),
                longint'(bx), longint'(by), longint'(bz));
      e.edge_no = cyc + 1;
      sb.push_back(e);
      acc_q.push_back(cyc + 1);
    end
  end

  // Output monitor: latency on the rising of out_valid, data on each handshake
  always @(negedge clk) begin
    if (rst) begin
      prev_ov <= 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        rise_q.push_back(cyc);
        check("sb_depth_at_valid", sb.size(), 1);
        if (sb.size() > 0) check("latency", cyc - sb[0].edge_no, 6);
      end
      if (out_valid && out_ready) begin
        if (sb.size() > 0) begin
          e_mon = sb.pop_front();
          check("rx", longint'(rx), e_mon.x);
          check("ry", longint'(ry), e_mon.y);
          check("rz", longint'(rz), e_mon.z);
        end else begin
          check("sb_depth_at_pop", sb.size(), 1);
        end
      end
      prev_ov <= out_valid;
    end
  end

  // Present a vector and hold in_valid until accepted; returns at accept edge + 1
  task automatic send(input logic signed [W-1:0] a0, input logic signed [W-1:0] a1,
                      input logic signed [W-1:0] a2, input logic signed [W-1:0] b0,
                      input logic signed [W-1:0] b1, input logic signed [W-1:0] b2,
                      input bit keep);
    bit acc;
    bit ok;
    ax = a0; ay = a1; az = a2;
    bx = b0; by = b1; bz = b2;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", longint'(ok), 1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit keep);
    send(rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp(), keep);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    sb.delete();
    acc_q.delete();
    rise_q.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  bit   rnd_done;
  exp_t e_bp;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    {ax, ay, az, bx, by, bz} = '0;
    apply_reset(3);

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rx", longint'(rx), 0);
    check("rst_ry", longint'(ry), 0);
    check("rst_rz", longint'(rz), 0);
    @(posedge clk); #1;

    // Basic vector with exact handshake timing
    out_ready = 1'b1;
    send(2, -5, 0, 0, -12, -2, 0);
    @(negedge clk);
    check("calc_in_ready", in_ready, 0);
    check("calc_busy", busy, 1);
    repeat (5) @(negedge clk);
    check("pre_e6_out_valid", out_valid, 0);
    @(negedge clk);
    check("e6_out_valid", out_valid, 1);
    check("e6_in_ready", in_ready, 0);
    check("basic_rx", longint'(rx), 10);
    check("basic_ry", longint'(ry), 4);
    check("basic_rz", longint'(rz), -24);
    @(negedge clk);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_busy", busy, 0);
    @(posedge clk); #1;

    // Extreme operands
    send(0, -128, -128, 0, 127, -128, 0);
    wait_done();
    check("ext1_rx", longint'(rx), 32640);
    send(-128, 127, 0, 0, -128, -128, 0);
    wait_done();
    check("ext2_rx", longint'(rx), -16256);
    check("ext2_ry", longint'(ry), -16384);
    check("ext2_rz", longint'(rz), 16384);

    // Backpressure: result held for 20 cycles
    out_ready = 1'b0;
    send_rand(0);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    check("bp_valid_seen", out_valid, 1);
    if (sb.size() > 0) begin
      e_bp = sb[0];
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        check("bp_rx", longint'(rx), e_bp.x);
        check("bp_rz", longint'(rz), e_bp.z);
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        check("bp_busy", busy, 1);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done();
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    @(posedge clk); #1;

    // Operand hold-off: new vector driven during CALC waits for the handshake
    acc_q.delete();
    send(1, 2, 3, 4, 5, 6, 0);
    ax = 9; ay = 9; az = 9;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("holdoff_in_ready", in_ready, 0);
    end
    @(negedge clk);
    check("holdoff_rx", longint'(rx), -3);
    check("holdoff_ry", longint'(ry), 6);
    check("holdoff_rz", longint'(rz), -3);
    for (int i = 0; i < 50 && acc_q.size() < 2; i++) @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("holdoff_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) check("holdoff_spacing", acc_q[1] - acc_q[0], 8);
    wait_done();

    // Reset in the middle of CALC (step 3)
    send_rand(0);
    repeat (3) @(posedge clk);
    #1;
    apply_reset(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 0);
    end
    check("mid_rst_rx", longint'(rx), 0);
    check("mid_rst_ry", longint'(ry), 0);
    check("mid_rst_rz", longint'(rz), 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    send(1, 0, 0, 0, 1, 0, 0);
    wait_done();
    check("fresh_rz", longint'(rz), 1);

    // Random vectors with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          send_rand(0);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_done();

    // Back-to-back with in_valid held high
    @(posedge clk); #1;
    acc_q.delete();
    rise_q.delete();
    for (int k = 0; k < 4; k++) send_rand(k < 3);
    wait_done();
    check("b2b_accepts", acc_q.size(), 4);
    check("b2b_results", rise_q.size(), 4);
    for (int k = 1; k < 4; k++) begin
      if (k < acc_q.size()) check("b2b_accept_spacing", acc_q[k] - acc_q[k-1], 8);
      if (k < rise_q.size()) check("b2b_result_spacing", rise_q[k] - rise_q[k-1], 8);
    end

    repeat (3) @(posedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
